// File: rtl/node_router.sv
// node_router: NUM_PORTS-port flit router with one FIFO per input and a round-robin arbiter per output.
// Define NODE_ROUTER_STATS_EN to add per-output consumed-flit counters on flit_count.
module node_router #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            receiving_data,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
  output logic [NUM_PORTS-1:0]            buffer_full_out,
  output logic [NUM_PORTS-1:0]            sending_data,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
  input  logic [NUM_PORTS-1:0]            buffer_full_in,
  output logic [1:0]                      err_status
`ifdef NODE_ROUTER_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0]         flit_count
`endif
);
  localparam int DEST_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [DEST_W:0]  NP_EXT   = (DEST_W+1)'(NUM_PORTS);

  logic [DATA_WIDTH-1:0] r_mem [NUM_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr [NUM_PORTS];
  logic [PTR_W-1:0]      r_rd_ptr [NUM_PORTS];
  logic [CNT_W-1:0]      r_count [NUM_PORTS];
  logic [NUM_PORTS-1:0]  r_full;
  logic [NUM_PORTS-1:0]  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data [NUM_PORTS];
  logic [DEST_W-1:0]     r_rr_ptr [NUM_PORTS];
  logic [1:0]            r_err;

  logic [DATA_WIDTH-1:0] w_head [NUM_PORTS];
  logic [DEST_W-1:0]     w_dest [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_head_valid;
  logic [NUM_PORTS-1:0]  w_bad;
  logic [NUM_PORTS-1:0]  w_pop;
  logic [NUM_PORTS-1:0]  w_push;
  logic [NUM_PORTS-1:0]  w_drop;
  logic [NUM_PORTS-1:0]  w_can_load;
  logic [NUM_PORTS-1:0]  w_gnt_any;
  logic [DEST_W-1:0]     w_gnt_idx [NUM_PORTS];
  logic [CNT_W-1:0]      w_count_nxt [NUM_PORTS];

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_head[i]       = r_mem[i][r_rd_ptr[i]];
      w_dest[i]       = w_head[i][DATA_WIDTH-1 -: DEST_W];
      w_head_valid[i] = (r_count[i] != '0);
      w_bad[i]        = w_head_valid[i] && ({1'b0, w_dest[i]} >= NP_EXT);
    end
  end

  // Each input head targets exactly one output, so one grant per input per cycle holds by construction.
  always_comb begin
    int                idx;
    logic              found;
    logic [DEST_W-1:0] cand;
    idx       = 0;
    found     = 1'b0;
    cand      = '0;
    w_gnt_any = '0;
    w_pop     = w_bad;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_gnt_idx[o]  = '0;
      w_can_load[o] = !r_out_valid[o] || !buffer_full_in[o];
      found         = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = int'(r_rr_ptr[o]) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        cand = DEST_W'(idx);
        if (w_can_load[o] && !found && w_head_valid[cand] && !w_bad[cand] &&
            (w_dest[cand] == DEST_W'(o))) begin
          found        = 1'b1;
          w_gnt_idx[o] = cand;
        end
      end
      w_gnt_any[o] = found;
      if (found) w_pop[w_gnt_idx[o]] = 1'b1;
    end
  end

  // A full FIFO still accepts when its head pops on the same edge.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_push[i]      = receiving_data[i] && ((r_count[i] != FULL_CNT) || w_pop[i]);
      w_drop[i]      = receiving_data[i] && !w_push[i];
      w_count_nxt[i] = r_count[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_wr_ptr[i]   <= '0;
        r_rd_ptr[i]   <= '0;
        r_count[i]    <= '0;
        r_out_data[i] <= '0;
        r_rr_ptr[i]   <= '0;
      end
      r_full      <= '0;
      r_out_valid <= '0;
      r_err       <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
        r_count[i] <= w_count_nxt[i];
        r_full[i]  <= (w_count_nxt[i] == FULL_CNT);
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_gnt_any[o]) begin
          r_out_valid[o] <= 1'b1;
          r_out_data[o]  <= w_head[w_gnt_idx[o]];
          r_rr_ptr[o]    <= (w_gnt_idx[o] == DEST_W'(NUM_PORTS-1)) ? '0 : w_gnt_idx[o] + DEST_W'(1);
        end else if (r_out_valid[o] && !buffer_full_in[o]) begin
          r_out_valid[o] <= 1'b0;
        end
      end
      r_err <= r_err | {|w_bad, |w_drop};
    end
  end

  always_comb begin
    data_out = '0;
    for (int o = 0; o < NUM_PORTS; o++) data_out[o*DATA_WIDTH +: DATA_WIDTH] = r_out_data[o];
  end

  assign sending_data    = r_out_valid;
  assign buffer_full_out = r_full;
  assign err_status      = r_err;

`ifdef NODE_ROUTER_STATS_EN
  logic [15:0] r_flit_cnt [NUM_PORTS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < NUM_PORTS; o++) r_flit_cnt[o] <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (r_out_valid[o] && !buffer_full_in[o]) r_flit_cnt[o] <= r_flit_cnt[o] + 16'd1;
      end
    end
  end

  always_comb begin
    flit_count = '0;
    for (int o = 0; o < NUM_PORTS; o++) flit_count[o*16 +: 16] = r_flit_cnt[o];
  end
`endif

endmodule

// File: tb/tb_node_router.sv
// Bench for node_router: a 4-port instance with a per-(source,dest) scoreboard and a 3-port instance
// for bad-destination handling. Flits carry dest in [15:14] and source port in [13:12].
module tb_node_router;
  localparam int NP = 4;
  localparam int DW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] receiving_data, buffer_full_in, buffer_full_out, sending_data;
  logic [NP*DW-1:0] data_in, data_out;
  logic [1:0]    err_status;
  logic [2:0]    rd3, bfo3, send3, bfi3;
  logic [3*DW-1:0] din3, dout3;
  logic [1:0]    err3;
`ifdef NODE_ROUTER_STATS_EN
  logic [NP*16-1:0] flit_count;
  logic [3*16-1:0]  flit_count3;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q [NP*NP][$];
  logic [DW-1:0] mon_got, mon_exp;
  int            mon_src;

  // clock / reset
  always #5 clk = ~clk;

  node_router #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) u_dut (
    .clk(clk), .reset(reset), .receiving_data(receiving_data), .data_in(data_in),
    .buffer_full_out(buffer_full_out), .sending_data(sending_data), .data_out(data_out),
    .buffer_full_in(buffer_full_in), .err_status(err_status)
`ifdef NODE_ROUTER_STATS_EN
    , .flit_count(flit_count)
`endif
  );

  node_router #(.NUM_PORTS(3), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) u_dut3 (
    .clk(clk), .reset(reset), .receiving_data(rd3), .data_in(din3),
    .buffer_full_out(bfo3), .sending_data(send3), .data_out(dout3),
    .buffer_full_in(bfi3), .err_status(err3)
`ifdef NODE_ROUTER_STATS_EN
    , .flit_count(flit_count3)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    receiving_data = '0;
    data_in        = '0;
  endtask

  task automatic offer(input int p, input logic [DW-1:0] d, input bit expect_accept);
    receiving_data[p]   = 1'b1;
    data_in[p*DW +: DW] = d;
    if (expect_accept) exp_q[p*NP + int'(d[15:14])].push_back(d);
  endtask

  task automatic check_drained(input string tag);
    int total = 0;
    for (int i = 0; i < NP*NP; i++) total += exp_q[i].size();
    check(tag, 64'(total), 64'd0);
  endtask

  // scoreboard: every consumed flit must be the oldest outstanding one for its (source, dest) pair
  always @(negedge clk) begin
    if (reset) begin
      for (int o = 0; o < NP; o++) begin
        if (sending_data[o] && !buffer_full_in[o]) begin
          mon_got = data_out[o*DW +: DW];
          mon_src = int'(mon_got[13:12]);
          if (exp_q[mon_src*NP + o].size() == 0) begin
            check($sformatf("spurious_out%0d_0x%0h", o, mon_got), 64'(sending_data[o]), 64'd0);
          end else begin
            mon_exp = exp_q[mon_src*NP + o].pop_front();
            check($sformatf("out%0d_data", o), 64'(mon_got), 64'(mon_exp));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] cont_exp [3];
    int dest;
    cont_exp = '{16'h1111, 16'h2222, 16'h3333};
    reset = 1'b0;
    receiving_data = '0; data_in = '0; buffer_full_in = '0;
    rd3 = '0; din3 = '0; bfi3 = '0;

    #12;
    check("rst_send", 64'(sending_data), 64'd0);
    check("rst_dout", 64'(data_out), 64'd0);
    check("rst_full", 64'(buffer_full_out), 64'd0);
    check("rst_err", 64'(err_status), 64'd0);
    check("rst_send3", 64'(send3), 64'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rel_send", 64'(sending_data), 64'd0);

    // bad destination on the 3-port router, then a loopback flit proves FIFO 1 drained
    tick();
    rd3 = 3'b010; din3[DW +: DW] = 16'hC000;
    tick();
    rd3 = '0; din3 = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bad_no_out", 64'(send3), 64'd0);
    end
    check("bad_err", 64'(err3), 64'd2);
    tick();
    rd3 = 3'b010; din3[DW +: DW] = 16'h4000;
    tick();
    rd3 = '0; din3 = '0;
    @(negedge clk);
    check("loop3_lat1", 64'(send3), 64'd0);
    @(negedge clk);
    check("loop3_send", 64'(send3), 64'd2);
    check("loop3_data", 64'(dout3[DW +: DW]), 64'h4000);

    // single flit, port 0 -> dest 2
    tick();
    offer(0, 16'h8ABC, 1);
    tick();
    clear_inputs();
    @(negedge clk);
    check("single_lat1", 64'(sending_data), 64'd0);
    @(negedge clk);
    check("single_send", 64'(sending_data), 64'h4);
    check("single_data", 64'(data_out[2*DW +: DW]), 64'h8ABC);
    @(negedge clk);
    check("single_after", 64'(sending_data), 64'd0);

    // contention: ports 1,2,3 -> dest 0 in one cycle
    tick();
    offer(1, 16'h1111, 1); offer(2, 16'h2222, 1); offer(3, 16'h3333, 1);
    tick();
    clear_inputs();
    @(negedge clk);
    check("cont_lat1", 64'(sending_data), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("cont_send%0d", k), 64'(sending_data), 64'h1);
      check($sformatf("cont_data%0d", k), 64'(data_out[DW-1:0]), 64'(cont_exp[k]));
    end
    @(negedge clk);
    check("cont_after", 64'(sending_data), 64'd0);

    // backpressure on output 1 while port 0 streams 6 flits
    tick();
    buffer_full_in = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      offer(0, 16'h4000 + 16'(k), k < 5);
      tick();
      check($sformatf("bp_full_out0_%0d", k), 64'(buffer_full_out[0]), 64'(k >= 4));
      check($sformatf("bp_err0_%0d", k), 64'(err_status[0]), 64'(k == 5));
      if (k >= 1) begin
        check("bp_hold_valid", 64'(sending_data[1]), 64'd1);
        check("bp_hold_data", 64'(data_out[DW +: DW]), 64'h4000);
      end
    end
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_valid", 64'(sending_data[1]), 64'd1);
      check("bp_hold_data", 64'(data_out[DW +: DW]), 64'h4000);
    end
    check("bp_full_pre_release", 64'(buffer_full_out[0]), 64'd1);
    buffer_full_in = '0;
    offer(0, 16'h4006, 1);
    tick();
    clear_inputs();
    check("bp_full_push_pop", 64'(buffer_full_out[0]), 64'd1);
    check("bp_err_no_new_drop", 64'(err_status), 64'd1);
    repeat (12) tick();
    check("bp_full_drained", 64'(buffer_full_out), 64'd0);
    check_drained("bp_drain");

    // random traffic with random downstream stalls
    for (int c = 0; c < 300; c++) begin
      clear_inputs();
      for (int p = 0; p < NP; p++) begin
        if (!buffer_full_out[p] && ($urandom_range(0, 99) < 60)) begin
          dest = $urandom_range(0, NP-1);
          offer(p, {2'(dest), 2'(p), 12'($urandom_range(0, 4095))}, 1);
        end
      end
      buffer_full_in = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      tick();
    end
    clear_inputs();
    buffer_full_in = '0;
    repeat (40) tick();
    check_drained("rand_drain");
    check("rand_err", 64'(err_status), 64'd1);

    // reset with flits buffered and held in stalled output registers
    buffer_full_in = 4'hF;
    offer(0, 16'h4001, 0); offer(1, 16'h9002, 0); offer(2, 16'hE003, 0);
    tick();
    clear_inputs();
    tick();
    check("pre_rst_send", 64'(sending_data), 64'hE);
    reset = 1'b0;
    #1;
    check("mid_rst_send", 64'(sending_data), 64'd0);
    check("mid_rst_dout", 64'(data_out), 64'd0);
    check("mid_rst_err", 64'(err_status), 64'd0);
    check("mid_rst_err3", 64'(err3), 64'd0);
    check("mid_rst_full", 64'(buffer_full_out), 64'd0);
    tick();
    reset = 1'b1;
    buffer_full_in = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_idle", 64'(sending_data), 64'd0);
    end
    tick();
    offer(3, 16'h3ABC, 1);
    tick();
    clear_inputs();
    repeat (4) tick();
    check_drained("post_rst_drain");

`ifdef NODE_ROUTER_STATS_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("stats_zero", 64'(flit_count), 64'd0);
    for (int k = 0; k < 65536 + 5; k++) begin
      offer(3, {4'hF, 12'(k)}, 1);
      tick();
      clear_inputs();
    end
    repeat (10) tick();
    check("stats_wrap", 64'(flit_count[3*16 +: 16]), 64'd5);
    check("stats_others", 64'(flit_count[3*16-1:0]), 64'd0);
    check_drained("stats_drain");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/node_router.md
NODE_ROUTER -- requirements
Module: node_router

Interface
REQ-001 Parameter NUM_PORTS, default 4: router ports; port 0 is the local node. Legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 16: flit width in bits.
REQ-003 Parameter FIFO_DEPTH, default 4: entries per input buffer. Power of two, at least 2.
REQ-004 Derived DEST_W = clog2(NUM_PORTS), minimum 1. The destination field is data[DATA_WIDTH-1 -: DEST_W].
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 receiving_data  in  NUM_PORTS  per-port input flit valid.
REQ-008 data_in  in  NUM_PORTS*DATA_WIDTH  input flits; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-009 buffer_full_out  out  NUM_PORTS  input FIFO p is full.
REQ-010 sending_data  out  NUM_PORTS  per-port output flit valid.
REQ-011 data_out  out  NUM_PORTS*DATA_WIDTH  output flits, same packing as data_in.
REQ-012 buffer_full_in  in  NUM_PORTS  downstream on port p cannot accept a flit.
REQ-013 err_status  out  2  sticky flags: bit0 = overflow drop, bit1 = bad-destination drop.

Function
REQ-014 Each input port SHALL have a FIFO of FIFO_DEPTH entries with separate read and write pointers and a count.
- Pointers wrap modulo FIFO_DEPTH.
- A flit is pushed when receiving_data[p]=1 and the FIFO is not full.
- A flit offered while the FIFO is full is dropped and sets err_status[0].
REQ-015 buffer_full_out[p] SHALL be asserted when count == FIFO_DEPTH. It is registered from count and asserted in the same cycle the count reaches full.
REQ-016 A head flit whose destination is >= NUM_PORTS SHALL be popped without forwarding and SHALL set err_status[1].
REQ-017 Each output port SHALL have a round-robin arbiter over the input heads requesting it.
- Priority pointer: the input after the last granted input.
- The pointer updates only on a grant.
- Local loopback (destination = source port) is legal.
REQ-018 Output o SHALL grant only when its output register is empty, or it is valid and buffer_full_in[o]=0 in that cycle.
REQ-019 On a grant, the winning FIFO SHALL pop and the flit SHALL be loaded into output register o in the same edge.
REQ-020 sending_data[o] and data_out[o] SHALL hold stable while buffer_full_in[o]=1.
REQ-021 A flit is consumed on a cycle where sending_data[o]=1 and buffer_full_in[o]=0.
REQ-022 Minimum latency from acceptance to sending_data SHALL be 2 cycles.
- Edge t: write the FIFO.
- Edge t+1: grant and load the output register.
REQ-023 A simultaneous push and pop on one FIFO SHALL leave count unchanged. A pop in the same edge a full FIFO is offered a flit SHALL let that flit be accepted.
REQ-024 Each output SHALL grant at most one input per cycle, and each input SHALL be granted at most one output per cycle.
REQ-025 Flits from one input to one output SHALL leave in arrival order.

Reset
REQ-026 While reset=0, asynchronously:
- all FIFO pointers and counts = 0;
- buffer_full_out = 0;
- sending_data = 0;
- data_out = 0;
- arbiter pointers = 0;
- err_status = 0.
REQ-027 Reset asserted mid-transfer SHALL discard all buffered and output flits. No flit is emitted in the first cycle after release.

Configuration
REQ-028 Macro NODE_ROUTER_STATS_EN SHALL control per-output statistics.
- Defined: add output flit_count (NUM_PORTS*16 bits), one 16-bit counter per output port. A counter increments on each consumed flit (REQ-021), wraps at 0xFFFF to 0, and resets to 0.
- Undefined: the port and the counters are absent, and all other behaviour is identical.

Verification
REQ-029 Single flit, NUM_PORTS=4: port 0 sends 0x8ABC (dest 2) at cycle 0, downstream idle -> sending_data[2]=1, data_out[2]=0x8ABC at cycle 2, no other output valid.
REQ-030 Contention: ports 1, 2, 3 each send one flit with dest 0 in the same cycle, arbiter pointer at 0 -> output 0 emits the flits of 1, 2, 3 on three consecutive cycles.
REQ-031 Backpressure: buffer_full_in[1]=1 for 10 cycles while port 0 streams 6 flits to dest 1.
- During the stall: data_out[1] holds, buffer_full_out[0] rises after FIFO_DEPTH+1 accepts, and the 6th flit is dropped with err_status[0]=1.
- After release: 5 flits exit in order.
REQ-032 Bad destination, NUM_PORTS=3: flit 0xC000 (dest 3) on port 1 -> no output valid, err_status[1]=1, FIFO 1 empty 2 cycles later.
REQ-033 Reset mid-operation: assert reset with 3 flits buffered -> all outputs 0 immediately; after release, no sending_data until new input.
REQ-034 Stats build: 0x10000 flits through output 3 -> flit_count[3] wraps to 0.
